// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for mem_port_arbiter: FSM states, dsize codes,
// source encoding and the data-port legality check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  // lo holds the two least-significant address bits in big-endian order
  // (lo[1] is the byte-offset LSB).
  function automatic logic access_err(input logic [1:0] size, input logic [0:1] lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lo[1];
      SZ_WORD: err = |lo;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise D has fixed priority over I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_src,
  output logic pick_i,
  output logic pick_d
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    if (i_req && d_req) begin
      if (last_src == SRC_D) pick_i = 1'b1;
      else                   pick_d = 1'b1;
    end else begin
      pick_i = i_req;
      pick_d = d_req;
    end
  end
`else
  logic unused_last_src;
  assign unused_last_src = last_src;

  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
    pick_d = d_req;
    pick_i = i_req & ~d_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported dmem between a fetch port (I) and a load/store port (D).
// Optional round-robin arbitration with MEM_ARB_RR_EN; default is D-over-I priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [0:ADDR_W-1] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [0:31]       i_rdata,
  input  logic              d_req,
  input  logic [0:ADDR_W-1] d_addr,
  input  logic [0:31]       d_wdata,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [0:31]       d_rdata,
  output logic              d_err,
  output logic [0:ADDR_W-1] m_addr,
  output logic [0:31]       m_wdata,
  output logic              m_we,
  output logic [1:0]        m_size,
  input  logic [0:31]       m_rdata
);

  localparam int unsigned CNT_W = (LATENCY <= 1) ? 1 : $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state_q, state_nxt;
  logic              src_q;
  logic [0:ADDR_W-1] addr_q;
  logic [0:31]       wdata_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [0:31]       i_rdata_q, d_rdata_q;
  logic              last_src;
  logic              pick_i, pick_d;
  logic              gnt_i, gnt_d;
  logic              err_lat;
  logic              cnt_done;

  mem_arb_pick u_pick (
    .i_req    (i_req),
    .d_req    (d_req),
    .last_src (last_src),
    .pick_i   (pick_i),
    .pick_d   (pick_d)
  );

`ifdef MEM_ARB_RR_EN
  logic last_src_q;

  always_ff @(posedge clk) begin
    if (!rst_n)     last_src_q <= SRC_D;
    else if (gnt_d) last_src_q <= SRC_D;
    else if (gnt_i) last_src_q <= SRC_I;
  end

  assign last_src = last_src_q;
`else
  assign last_src = SRC_D;
`endif

  // Legality is judged on the latched fields so it stays valid through RESP.
  assign err_lat  = (src_q == SRC_D) && access_err(size_q, addr_q[ADDR_W-2:ADDR_W-1]);
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_nxt = state_q;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n) begin
          gnt_i = pick_i;
          gnt_d = pick_d;
          if (pick_i || pick_d) state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= SRC_D;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      size_q    <= SZ_BYTE;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        ST_IDLE: begin
          if (gnt_d) begin
            src_q   <= SRC_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
            size_q  <= d_size;
            cnt_q   <= CNT_LOAD;
          end else if (gnt_i) begin
            src_q   <= SRC_I;
            addr_q  <= i_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_WORD;
            cnt_q   <= CNT_LOAD;
          end
        end
        ST_ACCESS: begin
          if (cnt_done) begin
            if (src_q == SRC_D) d_rdata_q <= m_rdata;
            else                i_rdata_q <= m_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i_gnt   = gnt_i;
  assign d_gnt   = gnt_d;
  assign i_valid = (state_q == ST_RESP) && (src_q == SRC_I);
  assign d_valid = (state_q == ST_RESP) && (src_q == SRC_D);
  assign d_err   = d_valid && err_lat;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_size  = size_q;
  // Write strobe fires on the edge that ends the access, together with read capture.
  assign m_we    = rst_n && (state_q == ST_ACCESS) && cnt_done && we_q && !err_lat;

endmodule
